// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Purpose  : Shared UART frame format and bit-timing definitions used by
//             both the transmitter and the receiver, so both ends of the
//             link agree on bit time, data width and state encoding.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Default bit timing; both link partners must use the same values.
    localparam int CLKS_PER_BIT_DEF = 16;
    localparam int STOP_BITS_DEF    = 1;
    localparam int DATA_BITS        = 8;

    // Transmit/receive FSM state encoding.
    typedef logic [1:0] state_t;

    localparam state_t c_st_idle  = 2'd0;
    localparam state_t c_st_start = 2'd1;
    localparam state_t c_st_data  = 2'd2;
    localparam state_t c_st_stop  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/uart_baud_cnt.sv
`default_nettype none
// ============================================================================
//  Module   : uart_baud_cnt
//  Purpose  : Bit-time counter. Counts 0..CLKS_PER_BIT-1 and wraps; o_tick
//             marks the last clock of each bit period. Holding i_clear keeps
//             the count at zero so the next bit starts with a full period.
//  Ports    : clk      - system clock
//             rst      - asynchronous reset, active low
//             i_clear  - hold counter at zero
//             o_tick   - high during the final clock of a bit period
//  Revision : 1.0 - initial release
// ============================================================================
module uart_baud_cnt
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    output logic o_tick
);

    localparam int c_cnt_w = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(CLKS_PER_BIT - 1);

    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_clear || o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = (r_cnt == c_cnt_max);

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx
//  Purpose  : UART transmitter, 8 data bits, no parity, 1 or 2 stop bits,
//             LSB first. A one-entry holding register lets the next byte be
//             queued while the current frame shifts out, so consecutive
//             frames run back to back with no idle gap.
//  Ports    : clk     - system clock, rising edge
//             rst     - asynchronous reset, active low
//             data_in - byte to send, captured only when accepted
//             send    - request; accepted on a clock edge with send && ready
//             ready   - holding register empty
//             busy    - a frame is on the line
//             done    - one-cycle pulse in the last clock of the final stop bit
//             tx      - registered serial output, idles high
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int STOP_BITS    = STOP_BITS_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       send,
    output logic       ready,
    output logic       busy,
    output logic       done,
    output logic       tx
);

    state_t      r_state;
    logic [7:0]  r_hold_data;
    logic        r_hold_full;
    logic [7:0]  r_shift;
    logic [2:0]  r_bit_idx;
    logic [0:0]  r_stop_cnt;
    logic        r_tx;

    logic w_tick;
    logic w_accept;
    logic w_stop_last;

    // The counter is parked at zero while idle; every other state change
    // happens on a tick, where the counter wraps to zero by itself, so each
    // state is entered with a fresh bit period.
    uart_baud_cnt #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clear (r_state == c_st_idle),
        .o_tick  (w_tick)
    );

    assign w_accept    = send && !r_hold_full;
    assign w_stop_last = (r_stop_cnt == 1'(STOP_BITS - 1));

    // Accept (needs hold empty) and load (needs hold full) are mutually
    // exclusive, so both may update r_hold_full in the same block safely.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= c_st_idle;
            r_hold_data <= '0;
            r_hold_full <= 1'b0;
            r_shift     <= '0;
            r_bit_idx   <= '0;
            r_stop_cnt  <= '0;
            r_tx        <= 1'b1;
        end else begin
            if (w_accept) begin
                r_hold_data <= data_in;
                r_hold_full <= 1'b1;
            end

            case (r_state)
                c_st_idle: begin
                    if (r_hold_full) begin
                        r_shift     <= r_hold_data;
                        r_hold_full <= 1'b0;
                        r_bit_idx   <= '0;
                        r_tx        <= 1'b0;
                        r_state     <= c_st_start;
                    end
                end

                c_st_start: begin
                    if (w_tick) begin
                        r_tx    <= r_shift[0];
                        r_state <= c_st_data;
                    end
                end

                c_st_data: begin
                    if (w_tick) begin
                        if (r_bit_idx == 3'd7) begin
                            r_tx       <= 1'b1;
                            r_stop_cnt <= '0;
                            r_state    <= c_st_stop;
                        end else begin
                            // tx takes the bit that will be in shift[0]
                            // after this shift.
                            r_shift   <= r_shift >> 1;
                            r_tx      <= r_shift[1];
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end
                end

                c_st_stop: begin
                    if (w_tick) begin
                        if (w_stop_last) begin
                            if (r_hold_full) begin
                                // Queued byte: next start bit follows
                                // immediately, no idle cycle.
                                r_shift     <= r_hold_data;
                                r_hold_full <= 1'b0;
                                r_bit_idx   <= '0;
                                r_tx        <= 1'b0;
                                r_state     <= c_st_start;
                            end else begin
                                r_state <= c_st_idle;
                            end
                        end else begin
                            r_stop_cnt <= r_stop_cnt + 1'b1;
                        end
                    end
                end

                default: begin
                    r_tx    <= 1'b1;
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign ready = !r_hold_full;
    assign busy  = (r_state != c_st_idle);
    assign done  = (r_state == c_st_stop) && w_tick && w_stop_last;
    assign tx    = r_tx;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx
//  Purpose  : Self-checking bench for uart_tx. One instance with one stop
//             bit, one with two. Table of directed frames plus hand-written
//             back-to-back, dropped-send and mid-frame reset sequences.
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

    localparam int C = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data1, data2;
    logic       send1, send2;
    logic       ready1, busy1, done1, tx1;
    logic       ready2, busy2, done2, tx2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx #(.CLKS_PER_BIT(16), .STOP_BITS(1)) dut1 (
        .clk     (clk),
        .rst     (rst),
        .data_in (data1),
        .send    (send1),
        .ready   (ready1),
        .busy    (busy1),
        .done    (done1),
        .tx      (tx1)
    );

    uart_tx #(.CLKS_PER_BIT(16), .STOP_BITS(2)) dut2 (
        .clk     (clk),
        .rst     (rst),
        .data_in (data2),
        .send    (send2),
        .ready   (ready2),
        .busy    (busy2),
        .done    (done2),
        .tx      (tx2)
    );

    typedef struct {
        int         sel;
        logic [7:0] data;
        logic [9:0] line;   // line level per bit slot: [0]=start ... [9]=stop
        int         len;    // frame length in clocks
    } vec_t;

    vec_t vecs[5];

    function automatic logic cur_tx(input int sel);
        return (sel != 0) ? tx2 : tx1;
    endfunction
    function automatic logic cur_done(input int sel);
        return (sel != 0) ? done2 : done1;
    endfunction
    function automatic logic cur_busy(input int sel);
        return (sel != 0) ? busy2 : busy1;
    endfunction
    function automatic logic cur_ready(input int sel);
        return (sel != 0) ? ready2 : ready1;
    endfunction

    task automatic chk(input string name, input logic ok,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Present a byte for one clock; afterwards the holding register is full.
    task automatic send_byte(input int sel, input logic [7:0] d);
        @(negedge clk);
        if (sel != 0) begin data2 = d; send2 = 1'b1; end
        else          begin data1 = d; send1 = 1'b1; end
        @(negedge clk);
        send1 = 1'b0;
        send2 = 1'b0;
        // Scribble data_in: it must not matter outside the accept edge.
        if (sel != 0) data2 = ~d; else data1 = ~d;
        chk("ready_low_after_accept", cur_ready(sel) == 1'b0,
            32'(cur_ready(sel)), 32'd0);
    endtask

    // Called between the accept edge k and edge k+1 (or right after the last
    // cycle of a previous frame). Checks tx/done/busy on every cycle, one
    // check per bit slot, and samples mid-bit to rebuild the byte.
    task automatic frame_check(input int sel, input logic [9:0] line,
                               input int len, input string tag,
                               output logic [7:0] rx);
        int nbits;
        int bad;
        int n;
        logic eb;
        logic ed;
        logic [31:0] got;
        logic [31:0] want;
        nbits = len / C;
        rx = '0;
        for (int p = 0; p < nbits; p++) begin
            eb   = (p < 10) ? line[p] : 1'b1;
            bad  = 0;
            got  = '0;
            want = '0;
            for (int c = 0; c < C; c++) begin
                @(negedge clk);
                n  = p * C + c;
                ed = (n == len - 1);
                if (n == 0)
                    chk({tag, " ready_after_load"}, cur_ready(sel) == 1'b1,
                        32'(cur_ready(sel)), 32'd1);
                if (cur_tx(sel) !== eb || cur_done(sel) !== ed || cur_busy(sel) !== 1'b1) begin
                    if (bad == 0) begin
                        got  = {29'd0, cur_busy(sel), cur_done(sel), cur_tx(sel)};
                        want = {29'd0, 1'b1, ed, eb};
                    end
                    bad++;
                end
                if (c == C / 2 && p >= 1 && p <= 8) rx[p-1] = cur_tx(sel);
            end
            chk($sformatf("%s bit%0d {busy,done,tx}", tag, p), bad == 0, got, want);
        end
    endtask

    task automatic idle_check(input int sel, input int cycles, input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (cur_busy(sel) !== 1'b0 || cur_tx(sel) !== 1'b1 || cur_done(sel) !== 1'b0)
                bad++;
        end
        chk(tag, bad == 0, 32'(bad), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rx;

        vecs[0] = '{sel: 0, data: 8'h55, line: 10'h2AA, len: 160};
        vecs[1] = '{sel: 0, data: 8'h00, line: 10'h200, len: 160};
        vecs[2] = '{sel: 0, data: 8'hFF, line: 10'h3FE, len: 160};
        vecs[3] = '{sel: 0, data: 8'hA5, line: 10'h34A, len: 160};
        vecs[4] = '{sel: 1, data: 8'h81, line: 10'h302, len: 176};

        rst   = 1'b0;
        send1 = 1'b0;
        send2 = 1'b0;
        data1 = 8'h00;
        data2 = 8'h00;

        // Reset state.
        repeat (3) @(negedge clk);
        chk("reset {ready,busy,done,tx} dut1", {ready1, busy1, done1, tx1} == 4'b1001,
            32'({ready1, busy1, done1, tx1}), 32'h9);
        chk("reset {ready,busy,done,tx} dut2", {ready2, busy2, done2, tx2} == 4'b1001,
            32'({ready2, busy2, done2, tx2}), 32'h9);
        rst = 1'b1;
        idle_check(0, 4, "idle after reset release");

        // Table-driven single frames.
        for (int i = 0; i < 5; i++) begin
            send_byte(vecs[i].sel, vecs[i].data);
            frame_check(vecs[i].sel, vecs[i].line, vecs[i].len,
                        $sformatf("vec%0d", i), rx);
            chk($sformatf("vec%0d received byte", i), rx == vecs[i].data,
                32'(rx), 32'(vecs[i].data));
            idle_check(vecs[i].sel, 3, $sformatf("vec%0d idle after frame", i));
        end

        // Back-to-back: 0xAA, then 0x3C queued during DATA, then 0x11
        // offered while the holding register is full (must be dropped).
        send_byte(0, 8'hAA);
        fork
            begin
                frame_check(0, 10'h354, 160, "b2b first", rx);
                chk("b2b first byte", rx == 8'hAA, 32'(rx), 32'hAA);
                frame_check(0, 10'h278, 160, "b2b second", rx);
                chk("b2b second byte", rx == 8'h3C, 32'(rx), 32'h3C);
            end
            begin
                repeat (40) @(negedge clk);
                send_byte(0, 8'h3C);
                repeat (20) @(negedge clk);
                chk("ready low before dropped send", ready1 == 1'b0,
                    32'(ready1), 32'd0);
                data1 = 8'h11;
                send1 = 1'b1;
                @(negedge clk);
                send1 = 1'b0;
                data1 = 8'h00;
            end
        join
        idle_check(0, 200, "no frame for dropped 0x11");

        // Reset during bit 3 of 0xF0 with 0x77 queued behind it.
        send_byte(0, 8'hF0);
        repeat (30) @(negedge clk);
        send_byte(0, 8'h77);
        repeat (40) @(negedge clk);
        chk("tx low in bit3 of 0xF0", tx1 == 1'b0, 32'(tx1), 32'd0);
        #2 rst = 1'b0;
        #1;
        chk("async reset {ready,busy,done,tx}", {ready1, busy1, done1, tx1} == 4'b1001,
            32'({ready1, busy1, done1, tx1}), 32'h9);
        @(negedge clk);
        rst = 1'b1;
        idle_check(0, 200, "queued byte cleared by reset");

        send_byte(0, 8'h0F);
        frame_check(0, 10'h21E, 160, "post-reset", rx);
        chk("post-reset byte", rx == 8'h0F, 32'(rx), 32'h0F);
        idle_check(0, 3, "idle after post-reset frame");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
